// File: rtl/skein_subkey_scheduler.sv
// Skein-1024 subkey scheduler: preloads selector words 13/14/15 through add64,
// then streams the 16 subkey words of subkey s over a valid/ready handshake.
module skein_subkey_scheduler (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [4:0] subkey_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [4:0] subkey_select_o,
  output logic [3:0] subkey_word_select_o,
  output logic       write_o,
  output logic [1:0] add_b_sel_o,
  output logic       word_valid_o,
  input  logic       word_ready_i
);

  localparam int unsigned SubkeyW   = 5;
  localparam int unsigned WordIdxW  = 4;
  localparam int unsigned BSelW     = 2;
  localparam logic [SubkeyW-1:0]  MaxSubkey = SubkeyW'(20);
  localparam logic [WordIdxW-1:0] LastWord  = WordIdxW'(15);
  localparam logic [BSelW-1:0]    BSelS     = BSelW'(3);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PREP13 = 3'd1,
    ST_PREP14 = 3'd2,
    ST_PREP15 = 3'd3,
    ST_STREAM = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [WordIdxW-1:0] idx_q, idx_d;
  logic [BSelW-1:0]    r_q, r_d;
  logic [SubkeyW-1:0]  subkey_select_q, subkey_select_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                write_q, write_d;
  logic                word_valid_q, word_valid_d;
  logic [WordIdxW-1:0] word_sel_q, word_sel_d;
  logic [BSelW-1:0]    add_b_sel_q, add_b_sel_d;

  // Next-state logic: start acceptance, preload sequence, stream index advance.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    r_d             = r_q;
    subkey_select_d = subkey_select_q;
    err_d           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (subkey_i <= MaxSubkey) begin
            subkey_select_d = subkey_i;
            r_d             = BSelW'(subkey_i % SubkeyW'(3));
            state_d         = ST_PREP13;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PREP13: state_d = ST_PREP14;
      ST_PREP14: state_d = ST_PREP15;
      ST_PREP15: begin
        idx_d   = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (word_ready_i) begin
          if (idx_q == LastWord) state_d = ST_DONE;
          else                   idx_d   = idx_q + WordIdxW'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    write_d      = 1'b0;
    word_valid_d = 1'b0;
    word_sel_d   = '0;
    add_b_sel_d  = '0;
    case (state_d)
      ST_PREP13: begin
        write_d     = 1'b1;
        word_sel_d  = WordIdxW'(13);
        add_b_sel_d = r_d;
      end
      ST_PREP14: begin
        write_d     = 1'b1;
        word_sel_d  = WordIdxW'(14);
        add_b_sel_d = (r_d == BSelW'(2)) ? BSelW'(0) : r_d + BSelW'(1);
      end
      ST_PREP15: begin
        write_d     = 1'b1;
        word_sel_d  = WordIdxW'(15);
        add_b_sel_d = BSelS;
      end
      ST_STREAM: begin
        word_valid_d = 1'b1;
        word_sel_d   = idx_d;
      end
      default: ;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      r_q             <= '0;
      subkey_select_q <= '0;
      err_q           <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      write_q         <= 1'b0;
      word_valid_q    <= 1'b0;
      word_sel_q      <= '0;
      add_b_sel_q     <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      r_q             <= r_d;
      subkey_select_q <= subkey_select_d;
      err_q           <= err_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      write_q         <= write_d;
      word_valid_q    <= word_valid_d;
      word_sel_q      <= word_sel_d;
      add_b_sel_q     <= add_b_sel_d;
    end
  end

  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign err_o                = err_q;
  assign subkey_select_o      = subkey_select_q;
  assign subkey_word_select_o = word_sel_q;
  assign write_o              = write_q;
  assign add_b_sel_o          = add_b_sel_q;
  assign word_valid_o         = word_valid_q;

endmodule

// File: tb/tb_skein_subkey_scheduler.sv
// Directed scoreboard bench for skein_subkey_scheduler.
module tb_skein_subkey_scheduler;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] subkey;
  logic       busy, done, err, write_s, valid, ready;
  logic [4:0] ssel;
  logic [3:0] wsel;
  logic [1:0] absel;

  int total = 0;
  int bad   = 0;
  int last_s = 0;

  // Expected per-cycle observation plus the inputs to drive for that cycle.
  typedef struct {
    logic [15:0] obs;
    logic        rdy;
    logic        st;
    logic [4:0]  sk;
    logic        abort;
  } ent_t;

  ent_t sb[$];

  skein_subkey_scheduler dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .start_i              (start),
    .subkey_i             (subkey),
    .busy_o               (busy),
    .done_o               (done),
    .err_o                (err),
    .subkey_select_o      (ssel),
    .subkey_word_select_o (wsel),
    .write_o              (write_s),
    .add_b_sel_o          (absel),
    .word_valid_o         (valid),
    .word_ready_i         (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic b, input logic d, input logic e,
                                     input logic w, input logic v, input int s,
                                     input int ws, input int ab);
    return {b, d, e, w, v, 5'(s), 4'(ws), 2'(ab)};
  endfunction

  function automatic logic [15:0] cur();
    return {busy, done, err, write_s, valid, ssel, wsel, absel};
  endfunction

  task automatic check(input string tag, input logic [15:0] exp);
    logic [15:0] o;
    o = cur();
    total++;
    assert (o === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (busy,done,err,wr,vld|ssel|wsel|bsel)", tag, o, exp);
    end
  endtask

  task automatic push(input logic [15:0] obs, input logic rdy, input logic st,
                      input int sk, input logic abort);
    ent_t e;
    e.obs = obs; e.rdy = rdy; e.st = st; e.sk = 5'(sk); e.abort = abort;
    sb.push_back(e);
  endtask

  // Drive one request and compare every cycle through the trailing IDLE cycle.
  task automatic run_seq(input int s, input int stall_idx, input int stall_n,
                         input int poke_idx, input int abort_idx);
    int r, k;
    ent_t e;
    r = s % 3;
    push(mk(1, 0, 0, 1, 0, s, 13, r), 1'b1, 1'b0, s, 1'b0);
    push(mk(1, 0, 0, 1, 0, s, 14, (r + 1) % 3), 1'b1, 1'b0, s, 1'b0);
    push(mk(1, 0, 0, 1, 0, s, 15, 3), 1'b1, 1'b0, s, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == stall_idx)
        for (int j = 0; j < stall_n; j++)
          push(mk(1, 0, 0, 0, 1, s, i, 0), 1'b0, 1'b0, s, 1'b0);
      push(mk(1, 0, 0, 0, 1, s, i, 0), 1'b1, (i == poke_idx),
           (i == poke_idx) ? 9 : s, (i == abort_idx));
    end
    push(mk(1, 1, 0, 0, 0, s, 0, 0), 1'b1, 1'b0, s, 1'b0);
    push(mk(0, 0, 0, 0, 0, s, 0, 0), 1'b1, 1'b0, s, 1'b0);
    start  = 1'b1;
    subkey = 5'(s);
    ready  = 1'b1;
    k = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("s%0d_step%0d", s, k), e.obs);
      start  = e.st;
      subkey = e.sk;
      ready  = e.rdy;
      if (e.abort) begin
        #2 rst = 1'b1;
        #1 check($sformatf("s%0d_async_reset", s), 16'h0000);
        sb.delete();
      end
      k++;
    end
    last_s = rst ? 0 : s;
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    subkey = '0;
    ready  = 1'b0;
    #1 check("reset_state", 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 16'h0000);

    run_seq(0, -1, 0, -1, -1);
    run_seq(4, -1, 0, -1, -1);
    run_seq(20, -1, 0, -1, -1);
    run_seq(7, 5, 3, -1, -1);

    // Out-of-range request: single err pulse, no busy, select unchanged.
    start  = 1'b1;
    subkey = 5'd21;
    @(negedge clk);
    check("err_pulse", mk(0, 0, 1, 0, 0, last_s, 0, 0));
    start = 1'b0;
    @(negedge clk);
    check("err_cleared", mk(0, 0, 0, 0, 0, last_s, 0, 0));

    // Start with s=9 during STREAM of s=3 must be ignored.
    run_seq(3, -1, 0, 6, -1);

    // Reset during STREAM index 8, then a full fresh sequence.
    run_seq(5, -1, 0, -1, 8);
    @(negedge clk);
    check("held_in_reset", 16'h0000);
    rst = 1'b0;
    run_seq(2, -1, 0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/skein_subkey_scheduler.md
# skein_subkey_scheduler

Sequencer for the Skein-1024 subkey selector datapath. For a requested subkey index s (0..20) it first loads subkey words 13, 14 and 15 into the selector's holding registers: key plus tweak word, key plus tweak word, and key plus s, respectively. It then streams all 16 subkey words, in index order, to the Threefish key-injection stage over a valid/ready handshake. It sits between the round controller, which requests subkeys, and the subkey selector / add64 pair.

## Interface
Parameters:
- None. Fixed for Skein-1024: 16 words per subkey, 21 subkeys (s = 0..20), 3 tweak words.

Ports:
- clk_i  in  1  system clock; all state updates on its rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  request subkey `subkey_i`; sampled only in IDLE
- subkey_i  in  5  requested subkey index s
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse after word 15 is accepted
- err_o  out  1  one-cycle pulse when a start is rejected
- subkey_select_o  out  5  latched s; drives the selector's subkey select
- subkey_word_select_o  out  4  current word index; drives the selector's word select
- write_o  out  1  write strobe for the selector's word 13/14/15 registers
- add_b_sel_o  out  2  add64 B-operand select: 0 = t0, 1 = t1, 2 = t2, 3 = s zero-extended to 64 bits
- word_valid_o  out  1  current subkey word (selector `word_o`) is valid
- word_ready_i  in  1  downstream accepts the word

## Operation
- States: IDLE, PREP13, PREP14, PREP15, STREAM, DONE.
- IDLE, start accepted: when `start_i`=1 and `subkey_i`<=20:
  - latch s into `subkey_select_o`;
  - latch r = s mod 3 (2-bit register, computed once at latch time);
  - go to PREP13.
- IDLE, start rejected: when `start_i`=1 and `subkey_i`>20, pulse `err_o`, stay in IDLE, leave `subkey_select_o` unchanged.
- PREP13: `subkey_word_select_o`=13, `write_o`=1, `add_b_sel_o`=r. Next state is PREP14.
- PREP14: `subkey_word_select_o`=14, `write_o`=1, `add_b_sel_o`=(r+1) mod 3. Next state is PREP15.
- PREP15: `subkey_word_select_o`=15, `write_o`=1, `add_b_sel_o`=3. Next state is STREAM with word index 0.
- add64 is combinational, so its sum is valid in the same cycle as `write_o`. The selector captures it at the end of that cycle.
- STREAM:
  - `word_valid_o`=1 and `subkey_word_select_o`=index.
  - On `word_valid_o`&&`word_ready_i`, the index increments.
  - On the handshake at index 15, go to DONE.
  - `write_o`=0 throughout STREAM.
- DONE: `done_o`=1 for one cycle, then go to IDLE. `busy_o` is still 1 in DONE.
- `start_i` is ignored in every state except IDLE. It is not queued.
- Word index is a 4-bit counter. Index 15 is terminal, so it never wraps past 15.
- Reset, including mid-sequence:
  - state returns to IDLE immediately;
  - the partially written 13/14/15 registers are left stale;
  - the next accepted start rewrites all three before streaming.

## Timing
- Reset values:
  - 0: `busy_o`, `done_o`, `err_o`, `write_o`, `word_valid_o`, `subkey_select_o`, `subkey_word_select_o`, `add_b_sel_o`.
  - State = IDLE; r = 0.
- Outputs in IDLE: `subkey_word_select_o`=0, `add_b_sel_o`=0, `write_o`=0, `word_valid_o`=0.
- All outputs are registered, or decoded from registered state only. There is no combinational path from `word_ready_i` to any output.
- Cycle numbering (start sampled at edge 0):
  - PREP13 = cycle 1, PREP14 = cycle 2, PREP15 = cycle 3;
  - first `word_valid_o` = cycle 4.
- With `word_ready_i` held high: one word per cycle, word 15 in cycle 19, `done_o` in cycle 20, back in IDLE at cycle 21.
- Start-to-done latency = 4 + 16 + N_stall cycles, where N_stall is the number of STREAM cycles with `word_ready_i`=0.
- Backpressure: while `word_ready_i`=0, the index and `word_valid_o` hold.
- The earliest next start is sampled in the first IDLE cycle, which gives back-to-back operation with one idle cycle.

## Test plan
- s=0, ready always 1:
  - writes at words 13/14/15 with `add_b_sel_o` 0/1/3;
  - word indices stream 0..15 in cycles 4..19;
  - `done_o` in cycle 20.
- s=4 (r=1): word 13 uses `add_b_sel_o`=1 and word 14 uses 2. Also s=20 (r=2): word 13 uses 2 and word 14 uses 0. In both cases `subkey_select_o` holds the requested value for the whole sequence.
- s=7 with `word_ready_i` low for 3 cycles at index 5:
  - index 5 and `word_valid_o` hold for those cycles;
  - `done_o` arrives 3 cycles later than nominal, i.e. cycle 23.
- `subkey_i`=21 with `start_i`: `err_o` pulses once, `busy_o` stays 0, no `write_o`.
- `start_i` with s=9 pulsed during STREAM of s=3: ignored; the s=3 sequence completes unchanged.
- `rst_i` asserted during STREAM index 8:
  - all outputs go to reset values asynchronously;
  - after release, start with s=2 produces the full PREP13..DONE sequence.
